// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : Program counter and fetch sequencing ahead of instruction memory.
//            Picks sequential / branch / JAL / JALR next-PC and runs the
//            BOOT/RUN/HALT/TRAP control state machine.
// Options  : FETCH_INSTRET_EN - adds the 64-bit retired-instruction counter
//            output 'instret'.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic            redirect_is_jalr,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_target
`ifdef FETCH_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam logic [XLEN-1:0] c_PC_STEP = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TRAP = 2'd3
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_bad_target;
    logic [XLEN-1:0] w_tgt;
    logic            w_tgt_misaligned;

    // JALR clears bit 0; only bit 1 makes a target misaligned (IALIGN=32).
    assign w_tgt            = redirect_is_jalr ? {redirect_target[XLEN-1:1], 1'b0}
                                               : redirect_target;
    assign w_tgt_misaligned = w_tgt[1];

    // Control state machine and PC register; HALT/TRAP only leave via rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_VECTOR;
            r_bad_target <= '0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (stall) begin
                        // Redirect arriving with a stall is dropped on purpose.
                        r_pc <= r_pc;
                    end else if (redirect_valid) begin
                        if (w_tgt_misaligned) begin
                            r_state      <= ST_TRAP;
                            r_bad_target <= w_tgt;
                        end else begin
                            r_pc <= w_tgt;
                        end
                    end else begin
                        r_pc <= r_pc + c_PC_STEP;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

`ifdef FETCH_INSTRET_EN
    logic [63:0] r_instret;
    logic        w_retire;

    // Retire on every unstalled RUN edge that does not take a trap (halt counts).
    assign w_retire = (r_state == ST_RUN) && !stall &&
                      !(!halt_req && redirect_valid && w_tgt_misaligned);

    // Retired-instruction counter, wraps at 2^64.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign instret = r_instret;
`endif

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + c_PC_STEP;
    assign bad_target  = r_bad_target;
    assign fetch_valid = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);
    assign misaligned  = (r_state == ST_TRAP);

endmodule
`default_nettype wire
